// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, stall/freeze and branch redirect/flush.
// The fetch FSM only tracks RUN/STALL for the companion checker; it never alters outputs.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [5:0]       if_id_opcode,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_STALL = 1'b1;
  localparam logic [31:0] PC_INC   = 32'(PC_STEP);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end else begin
      return value + CNT_W'(1);
    end
  endfunction

  logic [31:0]      pc_r;
  logic [31:0]      if_id_pc_r;
  logic [31:0]      if_id_instr_r;
  logic             if_id_valid_r;
  logic [CNT_W-1:0] fetch_count_r;
  logic [0:0]       state_r;

  logic [31:0]      pc_next_s;
  logic [31:0]      pc_seq_s;
  logic [31:0]      if_id_pc_next_s;
  logic [31:0]      if_id_instr_next_s;
  logic             if_id_valid_next_s;
  logic [CNT_W-1:0] fetch_count_next_s;
  logic [0:0]       state_next_s;

  assign pc_seq_s = pc_r + PC_INC;

  // Next-state selection: branch beats freeze beats sequential fetch.
  // branch_addr is only looked at under branch_taken so an X there cannot reach pc.
  always_comb begin
    pc_next_s          = pc_r;
    if_id_pc_next_s    = if_id_pc_r;
    if_id_instr_next_s = if_id_instr_r;
    if_id_valid_next_s = if_id_valid_r;
    fetch_count_next_s = fetch_count_r;
    if (branch_taken) begin
      pc_next_s          = word_align(branch_addr);
      if_id_pc_next_s    = 32'h0000_0000;
      if_id_instr_next_s = 32'h0000_0000;
      if_id_valid_next_s = 1'b0;
    end else if (freeze) begin
      pc_next_s          = pc_r;
    end else begin
      pc_next_s          = pc_seq_s;
      if_id_pc_next_s    = pc_seq_s;
      if_id_instr_next_s = imem_rdata;
      if_id_valid_next_s = 1'b1;
      fetch_count_next_s = sat_inc(fetch_count_r);
    end
  end

  // Fetch FSM transition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (freeze && !branch_taken) begin
          state_next_s = ST_STALL;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_STALL: begin
        if (!freeze || branch_taken) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_STALL;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // PC, IF/ID, counter and FSM registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
      fetch_count_r <= '0;
      state_r       <= ST_RUN;
    end else begin
      pc_r          <= pc_next_s;
      if_id_pc_r    <= if_id_pc_next_s;
      if_id_instr_r <= if_id_instr_next_s;
      if_id_valid_r <= if_id_valid_next_s;
      fetch_count_r <= fetch_count_next_s;
      state_r       <= state_next_s;
    end
  end

  assign imem_addr    = pc_r;
  assign if_id_pc     = if_id_pc_r;
  assign if_id_instr  = if_id_instr_r;
  assign if_id_valid  = if_id_valid_r;
  assign if_id_opcode = if_id_instr_r[31:26];
  assign fetch_count  = fetch_count_r;

  if_stage_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .pc           (pc_r),
    .if_id_pc     (if_id_pc_r),
    .if_id_instr  (if_id_instr_r),
    .if_id_valid  (if_id_valid_r),
    .fetch_count  (fetch_count_r),
    .state        (state_r)
  );

endmodule

// Property checks on the fetch stage; no logic here drives the design.
module if_stage_checker #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  input logic             freeze,
  input logic             branch_taken,
  input logic [31:0]      branch_addr,
  input logic [31:0]      pc,
  input logic [31:0]      if_id_pc,
  input logic [31:0]      if_id_instr,
  input logic             if_id_valid,
  input logic [CNT_W-1:0] fetch_count,
  input logic [0:0]       state
);

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
    pc[1:0] == 2'b00);

  a_empty_slot_is_nop: assert property (@(posedge clk) disable iff (rst)
    !if_id_valid |-> (if_id_instr == 32'h0000_0000 && if_id_pc == 32'h0000_0000));

  a_freeze_holds: assert property (@(posedge clk) disable iff (rst)
    (freeze && !branch_taken) |=> ($stable(pc) && $stable(if_id_instr) &&
                                   $stable(if_id_pc) && $stable(fetch_count)));

  a_branch_redirects: assert property (@(posedge clk) disable iff (rst)
    branch_taken |=> (!if_id_valid && pc == {$past(branch_addr[31:2]), 2'b00}));

  a_stall_tracks_freeze: assert property (@(posedge clk) disable iff (rst)
    (freeze && !branch_taken) |=> (state == 1'b1));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, freeze, branch flush, wrap and counter saturation.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [5:0]  if_id_opcode;
  logic [15:0] fetch_count;

  logic [31:0] s_imem_addr;
  logic [31:0] s_imem_rdata;
  logic [31:0] s_if_id_pc;
  logic [31:0] s_if_id_instr;
  logic        s_if_id_valid;
  logic [5:0]  s_if_id_opcode;
  logic [1:0]  s_fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction memory: word n holds n+100.
  assign imem_rdata   = (imem_addr >> 2) + 32'd100;
  assign s_imem_rdata = (s_imem_addr >> 2) + 32'd100;

  if_stage dut (
    .clk (clk), .rst (rst), .freeze (freeze), .branch_taken (branch_taken),
    .branch_addr (branch_addr), .imem_addr (imem_addr), .imem_rdata (imem_rdata),
    .if_id_pc (if_id_pc), .if_id_instr (if_id_instr), .if_id_valid (if_id_valid),
    .if_id_opcode (if_id_opcode), .fetch_count (fetch_count)
  );

  if_stage #(.CNT_W(2)) dut_sat (
    .clk (clk), .rst (rst), .freeze (freeze), .branch_taken (branch_taken),
    .branch_addr (branch_addr), .imem_addr (s_imem_addr), .imem_rdata (s_imem_rdata),
    .if_id_pc (s_if_id_pc), .if_id_instr (s_if_id_instr), .if_id_valid (s_if_id_valid),
    .if_id_opcode (s_if_id_opcode), .fetch_count (s_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                            input logic [31:0] instr, input logic valid, input logic [15:0] cnt);
    check({tag, ".pc"},    imem_addr, pc);
    check({tag, ".ifpc"},  if_id_pc, ipc);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check({tag, ".cnt"},   {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'hDEAD_BEEF;

    // T1: reset, then three free fetches
    tick(); tick();
    check_slot("t1_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    check("t1_reset.opcode", {26'd0, if_id_opcode}, 32'h0);
    check("t1_reset.satcnt", {30'd0, s_fetch_count}, 32'd0);
    rst = 1'b0;
    tick(); tick(); tick();
    check_slot("t1_run", 32'hC, 32'hC, 32'd102, 1'b1, 16'd3);

    // T2: freeze at pc=0x8 for four edges, then release
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    check_slot("t2_pre", 32'h8, 32'h8, 32'd101, 1'b1, 16'd2);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_slot("t2_frozen", 32'h8, 32'h8, 32'd101, 1'b1, 16'd2);
    end
    freeze = 1'b0;
    tick();
    check_slot("t2_release", 32'hC, 32'hC, 32'd102, 1'b1, 16'd3);
    tick();
    check_slot("t2_next", 32'h10, 32'h10, 32'd103, 1'b1, 16'd4);

    // T3: branch to 0x43 from pc=0x10 flushes IF/ID and aligns the target
    branch_taken = 1'b1; branch_addr = 32'h43;
    tick();
    branch_taken = 1'b0; branch_addr = 32'hFFFF_FFFF;
    check_slot("t3_flush", 32'h40, 32'h0, 32'h0, 1'b0, 16'd4);
    check("t3_flush.opcode", {26'd0, if_id_opcode}, 32'h0);
    tick();
    check_slot("t3_target", 32'h44, 32'h44, 32'd116, 1'b1, 16'd5);

    // Opcode path: word 0x2000_0000 holds 0x2000_0064, opcode 6'h08
    branch_taken = 1'b1; branch_addr = 32'h8000_0000;
    tick();
    branch_taken = 1'b0;
    tick();
    check_slot("op_fetch", 32'h8000_0004, 32'h8000_0004, 32'h2000_0064, 1'b1, 16'd6);
    check("op_fetch.opcode", {26'd0, if_id_opcode}, 32'h08);

    // T4: branch and freeze together, branch wins; then freeze alone holds
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h20;
    tick();
    branch_taken = 1'b0;
    check_slot("t4_both", 32'h20, 32'h0, 32'h0, 1'b0, 16'd6);
    tick();
    check_slot("t4_hold", 32'h20, 32'h0, 32'h0, 1'b0, 16'd6);
    freeze = 1'b0;

    // T5: wrap from 0xFFFF_FFFC to 0
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("t5_at_top.pc", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_slot("t5_wrap", 32'h0, 32'h0, 32'h4000_0063, 1'b1, 16'd7);
    check("t5_wrap.opcode", {26'd0, if_id_opcode}, 32'h10);

    // T6: reset while frozen at pc=0x24
    branch_taken = 1'b1; branch_addr = 32'h24;
    tick();
    branch_taken = 1'b0; freeze = 1'b1; rst = 1'b1;
    check("t6_pre.pc", imem_addr, 32'h24);
    tick();
    check_slot("t6_reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
    check("t6_reset.satcnt", {30'd0, s_fetch_count}, 32'd0);

    // Saturation: five fetches on the 2-bit counter stop at 3
    rst = 1'b0; freeze = 1'b0;
    tick(); tick(); tick();
    check("sat3.satcnt", {30'd0, s_fetch_count}, 32'd3);
    tick(); tick();
    check("sat5.satcnt", {30'd0, s_fetch_count}, 32'd3);
    check_slot("sat5_main", 32'h14, 32'h14, 32'd104, 1'b1, 16'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
